aes_inv_cipher_iter: RTL and testbench
======================================

# aes_inv_cipher_iter

Iterative, parametrised AES inverse-cipher engine: decrypts one 128-bit block per round-count iteration, one inverse round per clock. Supports AES-128/192/256 through the round-count parameter, runs ECB or CBC per block, and exchanges data over valid/ready handshakes. Round keys are pre-expanded upstream and written into an internal key file. The block replaces the fixed AES-128, free-running decryption datapath as the decrypt stage behind the encryption block.

## Interface
- NR, 10, number of rounds; legal values 10, 12, 14. The key file holds NR+1 entries.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- key_we  in  1  round-key write strobe.
- key_addr  in  4  round-key index, 0..NR.
- key_data  in  128  round key; bit [127:120] is byte 0.
- iv_we  in  1  loads the CBC chaining register from iv_data.
- iv_data  in  128  initialisation vector.
- cbc  in  1  mode, sampled at input accept; 1 = CBC, 0 = ECB.
- in_valid  in  1  ciphertext valid.
- in_ready  out  1  engine can accept a block.
- ct_in  in  128  ciphertext block.
- out_valid  out  1  plaintext valid.
- out_ready  in  1  consumer accepts the plaintext.
- pt_out  out  128  plaintext block.
- busy  out  1  high in ROUND or DONE.

## Operation
- Byte order: bit [127:120] is state byte s0,0. Bytes fill column-major, as in FIPS-197.
- Datapath:
  - InvShiftRows and InvMixColumns are combinational inside the block.
  - InvSubBytes uses 16 instances of the codebase's invsbox.
- FSM states: IDLE, ROUND, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready:
    - st <= ct_in ^ k[NR].
    - ct_hold <= ct_in.
    - mode_r <= cbc.
    - rnd <= NR-1.
    - Next state: ROUND.
- ROUND, when rnd != 0:
  - st <= InvMixColumns(InvSubBytes(InvShiftRows(st)) ^ k[rnd]).
  - rnd <= rnd-1.
- ROUND, when rnd == 0 (final round, no InvMixColumns):
  - pt_out <= (InvSubBytes(InvShiftRows(st)) ^ k[0]) ^ (mode_r ? chain : 0).
  - Next state: DONE.
- DONE:
  - out_valid = 1.
  - pt_out is held stable until out_ready.
  - On out_valid & out_ready:
    - If mode_r, chain <= ct_hold.
    - Next state: IDLE.
- Key writes:
  - Accepted only in IDLE and only when key_addr <= NR.
  - Writes in any other state, or to an out-of-range address, are dropped silently.
- iv_we:
  - Accepted only in IDLE.
  - Takes priority over a chain update; the two cannot coincide, because chain updates only in DONE.
- An in_valid arriving in IDLE in the same cycle as key_we or iv_we:
  - The write lands first.
  - The block is accepted in that cycle but uses the old key and IV contents; the new contents apply from the next block.
- cbc is sampled only at accept. Toggling it mid-block has no effect.
- The key file is not reset. Contents are undefined until written; the bench must load all NR+1 entries.

## Timing
- Reset, asynchronous on rst_n low:
  - Outputs: in_ready=1 after release, out_valid=0, busy=0, pt_out=0.
  - Internal: state=IDLE, chain=0, rnd=0, st=0.
- Reset mid-operation aborts the block with no output; chain returns to 0.
- Latency, with accept in cycle T:
  - ROUND occupies cycles T+1..T+NR.
  - out_valid is asserted from cycle T+NR+1.
  - NR=10: 11 cycles. NR=12: 13 cycles. NR=14: 15 cycles.
- Throughput: one block per NR+2 cycles at best, since the return to IDLE costs one cycle. There is no accept in DONE.
- in_ready is 0 throughout ROUND and DONE. Holding in_valid high in those states has no effect.
- Back-pressure: out_valid stays high and pt_out stays stable for every cycle that out_ready is low.

## Test plan
- Reset: assert rst_n=0 mid-ROUND -> out_valid=0, busy=0 and pt_out=0 immediately; in_ready=1 after release; no output for the aborted block.
- FIPS-197 C.1, NR=10, ECB:
  - Stimulus: load the expanded keys of 000102030405060708090a0b0c0d0e0f (k[10]=13111d7fe3944a17f307a78b4d2b30c5); apply ct 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Required: pt_out=00112233445566778899aabbccddeeff, with out_valid rising exactly 11 cycles after accept.
- FIPS-197 C.3, NR=14, ECB:
  - Stimulus: load key 000102…1f expanded; apply ct 8ea2b7ca516745bfeafc49904b496089.
  - Required: pt_out=00112233445566778899aabbccddeeff after 15 cycles.
- CBC, two blocks:
  - Stimulus: iv=000102…0f, then C1 and C2 from the SP800-38A F.2.1 vectors.
  - Required: P1=6bc1bee22e409f96e93d7e117393172a and P2=ae2d8a571e03ac9c9eb76fac45af8e51. This checks that chain takes C1 only at the output handshake.
- Back-pressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE while driving a second in_valid.
  - Required: pt_out is stable, in_ready=0 and the second block is not accepted until 1 cycle after the handshake.
- Key write while busy:
  - Stimulus: key_we to k[0] with garbage during ROUND.
  - Required: the current and next decryptions are unaffected. A key_addr of 15 written in IDLE is ignored.

Source files
------------

// File: rtl/aes_inv_cipher_iter_if.sv
// Handshake and configuration bus of the iterative AES inverse-cipher engine.
interface aes_inv_cipher_iter_if;
  logic         key_we;
  logic [3:0]   key_addr;
  logic [127:0] key_data;
  logic         iv_we;
  logic [127:0] iv_data;
  logic         cbc;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt_out;
  logic         busy;

  modport master (
    output key_we, key_addr, key_data, iv_we, iv_data, cbc, in_valid, ct_in, out_ready,
    input  in_ready, out_valid, pt_out, busy
  );

  modport slave (
    input  key_we, key_addr, key_data, iv_we, iv_data, cbc, in_valid, ct_in, out_ready,
    output in_ready, out_valid, pt_out, busy
  );
endinterface

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one inverse round per clock, NR in {10,12,14}.
// Round keys are pre-expanded upstream and written into a local key file.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for a block; key/IV writes accepted here only
// S_ROUND | one inverse round per cycle, rnd_q counts NR-1 down to 0
// S_DONE  | plaintext valid and held until the consumer takes it
module aes_inv_cipher_iter #(
  parameter int NR = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  aes_inv_cipher_iter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_e;

  localparam logic [3:0] NR4 = 4'(NR);

  state_e       state_q, state_d;
  logic [127:0] key_q [0:NR];
  logic [127:0] st_q, st_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] ct_hold_q, ct_hold_d;
  logic         mode_q, mode_d;
  logic [127:0] chain_q, chain_d;
  // chain value frozen at accept, so an IV write in the accept cycle only
  // affects the following block
  logic [127:0] chain_snap_q, chain_snap_d;
  logic [127:0] pt_q, pt_d;
  logic [127:0] sr, sb, ark, mc;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] b);
    return xt(xt(xt(b))) ^ b;
  endfunction

  function automatic logic [7:0] m11(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(b) ^ b;
  endfunction

  function automatic logic [7:0] m13(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
  endfunction

  function automatic logic [7:0] m14(input logic [7:0] b);
    return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
  endfunction

  // byte (row r, column c) lives at bits [127-8*(4c+r) -: 8]
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3);
      o[119-32*c -: 8] = m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3);
      o[111-32*c -: 8] = m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3);
      o[103-32*c -: 8] = m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3);
    end
    return o;
  endfunction

  assign sr = inv_shift_rows(st_q);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    invsbox u_isb (.a_i(sr[8*i +: 8]), .y_o(sb[8*i +: 8]));
  end

  assign ark = sb ^ key_q[rnd_q];
  assign mc  = inv_mix_columns(ark);

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.pt_out    = pt_q;

  // key file: written only while idle and only for in-range indices; not reset
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.key_we && bus.key_addr <= NR4)
      key_q[bus.key_addr] <= bus.key_data;
  end

  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      st_q         <= '0;
      rnd_q        <= '0;
      ct_hold_q    <= '0;
      mode_q       <= 1'b0;
      chain_q      <= '0;
      chain_snap_q <= '0;
      pt_q         <= '0;
    end else begin
      state_q      <= state_d;
      st_q         <= st_d;
      rnd_q        <= rnd_d;
      ct_hold_q    <= ct_hold_d;
      mode_q       <= mode_d;
      chain_q      <= chain_d;
      chain_snap_q <= chain_snap_d;
      pt_q         <= pt_d;
    end
  end

  // next-state and round datapath selection
  always_comb begin
    state_d      = state_q;
    st_d         = st_q;
    rnd_d        = rnd_q;
    ct_hold_d    = ct_hold_q;
    mode_d       = mode_q;
    chain_d      = chain_q;
    chain_snap_d = chain_snap_q;
    pt_d         = pt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.iv_we) chain_d = bus.iv_data;
        if (bus.in_valid) begin
          st_d         = bus.ct_in ^ key_q[NR];
          ct_hold_d    = bus.ct_in;
          mode_d       = bus.cbc;
          chain_snap_d = chain_q;
          rnd_d        = NR4 - 4'd1;
          state_d      = S_ROUND;
        end
      end
      S_ROUND: begin
        if (rnd_q != 4'd0) begin
          st_d  = mc;
          rnd_d = rnd_q - 4'd1;
        end else begin
          pt_d    = ark ^ (mode_q ? chain_snap_q : 128'd0);
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          if (mode_q) chain_d = ct_hold_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule

// AES inverse S-box lookup.
module invsbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  assign y_o = INV_SBOX[a_i];
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Directed bench for aes_inv_cipher_iter: FIPS-197 and SP800-38A vectors,
// latency, back-pressure, dropped key writes and mid-block reset.
module tb_aes_inv_cipher_iter;
  localparam logic [127:0] C1_CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C3_CT   = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] PT_STD  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] SP_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CB1     = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] CB2     = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] PB1     = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] PB2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] PB1_NOC = 128'h6bc0bce12a459991e134741a7f9e1925;
  localparam logic [127:0] GARBAGE = 128'hdeadbeef0badf00dcafebabe55aa33cc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         key_we, iv_we, cbc, in_valid, out_ready, sel14;
  logic [3:0]   key_addr;
  logic [127:0] key_data, iv_data, ct_in;
  logic         in_ready_m, out_valid_m, busy_m;
  logic [127:0] pt_out_m;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]   fsb [0:255];
  logic [127:0] rk  [0:14];

  aes_inv_cipher_iter_if b10 ();
  aes_inv_cipher_iter_if b14 ();

  aes_inv_cipher_iter #(.NR(10)) u_dut10 (.clk(clk), .rst_n(rst_n), .bus(b10.slave));
  aes_inv_cipher_iter #(.NR(14)) u_dut14 (.clk(clk), .rst_n(rst_n), .bus(b14.slave));

  assign b10.key_we    = key_we & ~sel14;
  assign b10.key_addr  = key_addr;
  assign b10.key_data  = key_data;
  assign b10.iv_we     = iv_we & ~sel14;
  assign b10.iv_data   = iv_data;
  assign b10.cbc       = cbc;
  assign b10.in_valid  = in_valid & ~sel14;
  assign b10.ct_in     = ct_in;
  assign b10.out_ready = out_ready;
  assign b14.key_we    = key_we & sel14;
  assign b14.key_addr  = key_addr;
  assign b14.key_data  = key_data;
  assign b14.iv_we     = iv_we & sel14;
  assign b14.iv_data   = iv_data;
  assign b14.cbc       = cbc;
  assign b14.in_valid  = in_valid & sel14;
  assign b14.ct_in     = ct_in;
  assign b14.out_ready = out_ready;

  assign in_ready_m  = sel14 ? b14.in_ready  : b10.in_ready;
  assign out_valid_m = sel14 ? b14.out_valid : b10.out_valid;
  assign busy_m      = sel14 ? b14.busy      : b10.busy;
  assign pt_out_m    = sel14 ? b14.pt_out    : b10.pt_out;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p ^= aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // forward S-box from its definition: GF(2^8) inverse followed by the affine map
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      fsb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {fsb[w[31:24]], fsb[w[23:16]], fsb[w[15:8]], fsb[w[7:0]]};
  endfunction

  // key schedule; key is left-aligned in 256 bits
  task automatic expand(input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = key[255-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end else if (nk > 6 && i % nk == 4) t = sub_word(t);
        w[i] = w[i-nk] ^ t;
      end
    end
    for (int r = 0; r <= nr; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic load_keys(input int nr);
    for (int a = 0; a <= nr; a++) begin
      @(negedge clk);
      key_we = 1'b1; key_addr = 4'(a); key_data = rk[a];
    end
    @(negedge clk);
    key_we = 1'b0;
  endtask

  task automatic load_iv(input logic [127:0] v);
    @(negedge clk);
    iv_we = 1'b1; iv_data = v;
    @(negedge clk);
    iv_we = 1'b0;
  endtask

  // hook 1: garbage into k[0] during ROUND; hook 2: garbage into k[NR] in the accept cycle
  task automatic decrypt(input logic [127:0] ct, input logic mode, input int hook,
                         output logic [127:0] pt, output int lat);
    int nr;
    nr = sel14 ? 14 : 10;
    @(negedge clk);
    ct_in = ct; cbc = mode; in_valid = 1'b1;
    if (hook == 2) begin key_we = 1'b1; key_addr = 4'(nr); key_data = GARBAGE; end
    @(negedge clk);
    in_valid = 1'b0; key_we = 1'b0; cbc = ~mode; ct_in = ~ct;
    lat = 1;
    while (!out_valid_m && lat < 40) begin
      if (hook == 1) begin key_we = 1'b1; key_addr = 4'd0; key_data = GARBAGE; end
      @(negedge clk);
      lat++;
    end
    key_we = 1'b0;
    pt = pt_out_m;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt;
    int lat, seen;
    key_we = 0; iv_we = 0; cbc = 0; in_valid = 0; out_ready = 0; sel14 = 0;
    key_addr = '0; key_data = '0; iv_data = '0; ct_in = '0;
    build_sbox();

    repeat (2) @(negedge clk);
    check("rst_out_valid", 128'(out_valid_m), 128'd0);
    check("rst_busy", 128'(busy_m), 128'd0);
    check("rst_pt_out", pt_out_m, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 128'(in_ready_m), 128'd1);

    // FIPS-197 C.1
    expand({IV, 128'd0}, 4, 10);
    load_keys(10);
    @(negedge clk);
    key_we = 1'b1; key_addr = 4'd15; key_data = GARBAGE;
    @(negedge clk);
    key_we = 1'b0;
    decrypt(C1_CT, 1'b0, 0, pt, lat);
    check("c1_pt", pt, PT_STD);
    check("c1_latency", 128'(lat), 128'd11);

    decrypt(C1_CT, 1'b0, 1, pt, lat);
    check("keywr_busy_cur", pt, PT_STD);
    decrypt(C1_CT, 1'b0, 0, pt, lat);
    check("keywr_busy_next", pt, PT_STD);
    decrypt(C1_CT, 1'b0, 2, pt, lat);
    check("keywr_at_accept", pt, PT_STD);
    load_keys(10);

    // back-pressure with a second block waiting
    @(negedge clk);
    ct_in = C1_CT; cbc = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    lat = 1;
    while (!out_valid_m && lat < 40) begin @(negedge clk); lat++; end
    check("bp_latency", 128'(lat), 128'd11);
    for (int i = 0; i < 5; i++) begin
      check("bp_pt_hold", pt_out_m, PT_STD);
      check("bp_valid_hold", 128'(out_valid_m), 128'd1);
      check("bp_in_ready", 128'(in_ready_m), 128'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_ready", 128'(in_ready_m), 128'd1);
    check("bp_not_yet_busy", 128'(busy_m), 128'd0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_second_accept", 128'(busy_m), 128'd1);
    lat = 1;
    while (!out_valid_m && lat < 40) begin @(negedge clk); lat++; end
    check("bp2_latency", 128'(lat), 128'd11);
    check("bp2_pt", pt_out_m, PT_STD);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // FIPS-197 C.3 on the NR=14 engine
    sel14 = 1'b1;
    expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
    load_keys(14);
    decrypt(C3_CT, 1'b0, 0, pt, lat);
    check("c3_pt", pt, PT_STD);
    check("c3_latency", 128'(lat), 128'd15);
    sel14 = 1'b0;

    // SP800-38A CBC, two blocks
    expand({SP_KEY, 128'd0}, 4, 10);
    load_keys(10);
    load_iv(IV);
    decrypt(CB1, 1'b1, 0, pt, lat);
    check("cbc_p1", pt, PB1);
    decrypt(CB2, 1'b1, 0, pt, lat);
    check("cbc_p2", pt, PB2);

    // reset in the middle of ROUND
    @(negedge clk);
    ct_in = CB1; cbc = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_busy", 128'(busy_m), 128'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid_m), 128'd0);
    check("midrst_busy", 128'(busy_m), 128'd0);
    check("midrst_pt_out", pt_out_m, 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready_m), 128'd1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid_m) seen++;
    end
    check("midrst_no_output", 128'(seen), 128'd0);
    decrypt(CB1, 1'b1, 0, pt, lat);
    check("chain_cleared", pt, PB1_NOC);
    load_iv(IV);
    decrypt(CB1, 1'b1, 0, pt, lat);
    check("iv_reload_p1", pt, PB1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
